// File: rtl/gb_timer.sv
// Game Boy DIV/TIMA/TMA/TAC timer block on the MMU bus.
// TIMA overflow goes through a one-cycle PENDING window before the TMA reload and IRQ.
`timescale 1ns/1ps
module gb_timer #(
    parameter logic [15:0] BASE_ADDR = 16'hFF04
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic [15:0] iAddr,
    input  logic [7:0]  iData,
    input  logic        iWe,
    output logic [7:0]  oData,
    output logic        oSelect,
    output logic        oTimerIrq,
    output logic [1:0]  oState
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        RELOAD  = 2'd2
    } ovfState_t;

    ovfState_t   rState;
    ovfState_t   wNextState;
    logic [15:0] rDiv;
    logic [7:0]  rTima;
    logic [7:0]  rTma;
    logic [2:0]  rTac;
    logic        rTickIn;

    logic [15:0] wOffset;
    logic        wHitDiv;
    logic        wHitTima;
    logic        wHitTma;
    logic        wHitTac;
    logic        wWrDiv;
    logic        wWrTima;
    logic        wWrTma;
    logic        wWrTac;
    logic        wSelBit;
    logic        wTickIn;
    logic        wFall;
    logic [7:0]  wTimaNext;

    // Bus decode: a subtract keeps the window relocatable through BASE_ADDR.
    assign wOffset  = iAddr - BASE_ADDR;
    assign oSelect  = (wOffset[15:2] == 14'd0);
    assign wHitDiv  = oSelect && (wOffset[1:0] == 2'd0);
    assign wHitTima = oSelect && (wOffset[1:0] == 2'd1);
    assign wHitTma  = oSelect && (wOffset[1:0] == 2'd2);
    assign wHitTac  = oSelect && (wOffset[1:0] == 2'd3);
    assign wWrDiv   = iWe && wHitDiv;
    assign wWrTima  = iWe && wHitTima;
    assign wWrTma   = iWe && wHitTma;
    assign wWrTac   = iWe && wHitTac;

    always_comb begin
        oData = 8'h00;
        if (wHitDiv)  oData = rDiv[15:8];
        if (wHitTima) oData = rTima;
        if (wHitTma)  oData = rTma;
        if (wHitTac)  oData = {5'b11111, rTac};
    end

    always_comb begin
        case (rTac[1:0])
            2'b00:   wSelBit = rDiv[9];
            2'b01:   wSelBit = rDiv[3];
            2'b10:   wSelBit = rDiv[5];
            default: wSelBit = rDiv[7];
        endcase
    end

    // Edges produced by clearing DIV or rewriting TAC show up here like any other edge.
    assign wTickIn = rTac[2] & wSelBit;
    assign wFall   = rTickIn & ~wTickIn;

    always_comb begin
        wNextState = rState;
        wTimaNext  = rTima;
        oTimerIrq  = 1'b0;
        case (rState)
            IDLE: begin
                if (wWrTima) begin
                    wTimaNext = iData;
                end else if (wFall) begin
                    if (rTima == 8'hFF) begin
                        wTimaNext  = 8'h00;
                        wNextState = PENDING;
                    end else begin
                        wTimaNext = rTima + 8'd1;
                    end
                end
            end
            PENDING: begin
                if (wWrTima) begin
                    wTimaNext  = iData;
                    wNextState = IDLE;
                end else begin
                    wTimaNext  = wWrTma ? iData : rTma;
                    wNextState = RELOAD;
                end
            end
            RELOAD: begin
                oTimerIrq  = ~iReset;
                wNextState = IDLE;
                if (wWrTma) wTimaNext = iData;
            end
            default: wNextState = IDLE;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            rDiv    <= 16'h0000;
            rTima   <= 8'h00;
            rTma    <= 8'h00;
            rTac    <= 3'b000;
            rTickIn <= 1'b0;
            rState  <= IDLE;
        end else begin
            rDiv    <= wWrDiv ? 16'h0000 : rDiv + 16'd1;
            rTima   <= wTimaNext;
            rTickIn <= wTickIn;
            rState  <= wNextState;
            if (wWrTma) rTma <= iData;
            if (wWrTac) rTac <= iData[2:0];
        end
    end

    assign oState = rState;

endmodule

// File: tb/tb_gb_timer.sv
// Bench for gb_timer: directed overflow/reset scenarios plus random bus traffic
// checked every cycle against a behavioural model of the timer.
`timescale 1ns/1ps
module tb_gb_timer;

    localparam logic [15:0] BASE = 16'hFF04;

    logic        iClock;
    logic        iReset;
    logic [15:0] iAddr;
    logic [7:0]  iData;
    logic        iWe;
    logic [7:0]  oData;
    logic        oSelect;
    logic        oTimerIrq;
    logic [1:0]  oState;

    int vecCount  = 0;
    int missCount = 0;
    logic [15:0] expQ[$];

    // Behavioural model state
    int mDiv, mTima, mTma, mTac;
    bit mPrev, mPending, mReload, mValid;

    gb_timer #(.BASE_ADDR(BASE)) dut (
        .iClock(iClock), .iReset(iReset), .iAddr(iAddr), .iData(iData), .iWe(iWe),
        .oData(oData), .oSelect(oSelect), .oTimerIrq(oTimerIrq), .oState(oState)
    );

    // Clock
    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int tickBitPos();
        case (mTac & 3)
            0: return 9;
            1: return 3;
            2: return 5;
            default: return 7;
        endcase
    endfunction

    function automatic logic [7:0] modelRead(input logic [15:0] a);
        if (a == BASE)         return 8'((mDiv >> 8) & 255);
        if (a == BASE + 16'd1) return 8'(mTima);
        if (a == BASE + 16'd2) return 8'(mTma);
        if (a == BASE + 16'd3) return 8'(248 + mTac);
        return 8'h00;
    endfunction

    task automatic modelUpdate(input bit rst, input bit we, input logic [15:0] addr,
                               input logic [7:0] data);
        bit tick, fall, wD, wA, wM, wC;
        if (rst) begin
            mDiv = 0; mTima = 0; mTma = 0; mTac = 0;
            mPrev = 0; mPending = 0; mReload = 0; mValid = 1;
            return;
        end
        tick = ((mTac >> 2) & 1) == 1 && ((mDiv >> tickBitPos()) & 1) == 1;
        fall = mPrev && !tick;
        wD = we && addr == BASE;
        wA = we && addr == BASE + 16'd1;
        wM = we && addr == BASE + 16'd2;
        wC = we && addr == BASE + 16'd3;
        if (mReload) begin
            mReload = 0;
            if (wM) mTima = data;
        end else if (mPending) begin
            mPending = 0;
            if (wA) mTima = data;
            else begin
                mTima   = wM ? int'(data) : mTma;
                mReload = 1;
            end
        end else if (wA) begin
            mTima = data;
        end else if (fall) begin
            if (mTima == 255) begin
                mTima    = 0;
                mPending = 1;
            end else begin
                mTima = mTima + 1;
            end
        end
        mDiv = wD ? 0 : (mDiv + 1) % 65536;
        if (wM) mTma = data;
        if (wC) mTac = data & 7;
        mPrev = tick;
    endtask

    // Driver: one full clock cycle; outputs are compared before the edge, model steps with it.
    task automatic step(input bit rst, input bit we, input logic [15:0] addr,
                        input logic [7:0] data);
        iReset = rst; iWe = we; iAddr = addr; iData = data;
        #1;
        if (mValid) begin
            expQ.push_back({8'h00, modelRead(addr)});
            expQ.push_back({15'd0, addr >= BASE && addr <= BASE + 16'd3});
            expQ.push_back({15'd0, mReload && !rst});
            check("rdata", {8'h00, oData}, expQ.pop_front());
            check("select", {15'd0, oSelect}, expQ.pop_front());
            check("irq", {15'd0, oTimerIrq}, expQ.pop_front());
        end
        modelUpdate(rst, we, addr, data);
        @(posedge iClock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, BASE + 16'd1, 8'h00);
    endtask

    task automatic peek(input string tag, input logic [15:0] addr, input logic [7:0] exp);
        iReset = 0; iWe = 0; iAddr = addr;
        #1;
        check(tag, {8'h00, oData}, {8'h00, exp});
    endtask

    task automatic peekIrq(input string tag, input logic exp);
        iReset = 0; iWe = 0;
        #1;
        check(tag, {15'd0, oTimerIrq}, {15'd0, exp});
    endtask

    // Reset, TMA=80, TIMA=FF, TAC=05, then run until TIMA wraps; ends in the PENDING cycle.
    task automatic setupOverflow();
        bit found;
        found = 0;
        step(1, 0, BASE, 8'h00);
        step(0, 1, BASE + 16'd2, 8'h80);
        step(0, 1, BASE + 16'd1, 8'hFF);
        step(0, 1, BASE + 16'd3, 8'h05);
        for (int i = 0; i < 40 && !found; i++) begin
            step(0, 0, BASE + 16'd1, 8'h00);
            if (oData == 8'h00) found = 1;
        end
        check("ovf_wait", {15'd0, found}, 16'd1);
    endtask

    initial begin
        iReset = 1; iWe = 0; iAddr = BASE; iData = 8'h00;
        mValid = 0;

        // Reset values and DIV behaviour
        step(1, 0, BASE, 8'h00);
        peek("rst_div", BASE, 8'h00);
        peek("rst_tima", BASE + 16'd1, 8'h00);
        peek("rst_tma", BASE + 16'd2, 8'h00);
        peek("rst_tac", BASE + 16'd3, 8'hF8);
        peek("unmapped", 16'hFF08, 8'h00);
        check("sel_low", {15'd0, oSelect}, 16'd0);
        idle(256 - 5);
        step(0, 0, BASE, 8'h00); step(0, 0, BASE, 8'h00); step(0, 0, BASE, 8'h00);
        step(0, 0, BASE, 8'h00); step(0, 0, BASE, 8'h00);
        peek("div_256", BASE, 8'h01);
        step(0, 1, BASE, 8'h5A);
        peek("div_clr", BASE, 8'h00);

        // TIMA counting at the rDiv[3] rate
        step(1, 0, BASE, 8'h00);
        step(0, 1, BASE + 16'd3, 8'h05);
        step(0, 1, BASE + 16'd1, 8'h00);
        step(0, 1, BASE, 8'h00);
        idle(15);
        peek("tima_15", BASE + 16'd1, 8'h00);
        idle(2);
        peek("tima_17", BASE + 16'd1, 8'h01);
        idle(238);
        peek("tima_255", BASE + 16'd1, 8'h0F);
        idle(2);
        peek("tima_257", BASE + 16'd1, 8'h10);

        // Plain overflow: 00 for one cycle, then TMA with a single IRQ cycle
        setupOverflow();
        peekIrq("pend_irq", 1'b0);
        idle(1);
        peek("reload_tima", BASE + 16'd1, 8'h80);
        peekIrq("reload_irq", 1'b1);
        idle(1);
        peekIrq("post_irq", 1'b0);
        peek("post_tima", BASE + 16'd1, 8'h80);

        // TIMA write in PENDING cancels reload and IRQ
        setupOverflow();
        step(0, 1, BASE + 16'd1, 8'h33);
        peek("cancel_tima", BASE + 16'd1, 8'h33);
        peekIrq("cancel_irq", 1'b0);
        idle(1);
        peekIrq("cancel_irq2", 1'b0);

        // TMA write in RELOAD lands in TIMA the same cycle
        setupOverflow();
        idle(1);
        peekIrq("tma_rl_irq", 1'b1);
        step(0, 1, BASE + 16'd2, 8'hC0);
        peek("tma_rl_tima", BASE + 16'd1, 8'hC0);
        peek("tma_rl_tma", BASE + 16'd2, 8'hC0);

        // Falling edges from DIV and TAC writes
        step(1, 0, BASE, 8'h00);
        step(0, 1, BASE + 16'd3, 8'h05);
        idle(7);
        step(0, 1, BASE, 8'h00);
        idle(1);
        peek("div_wr_edge", BASE + 16'd1, 8'h01);
        idle(7);
        step(0, 1, BASE + 16'd3, 8'h01);
        idle(1);
        peek("tac_wr_edge", BASE + 16'd1, 8'h02);
        idle(40);
        peek("tac_off", BASE + 16'd1, 8'h02);

        // Reset landing on the PENDING cycle
        setupOverflow();
        step(1, 0, BASE + 16'd1, 8'h00);
        peekIrq("rst_pend_irq", 1'b0);
        peek("rst_pend_div", BASE, 8'h00);
        peek("rst_pend_tima", BASE + 16'd1, 8'h00);
        peek("rst_pend_tma", BASE + 16'd2, 8'h00);
        peek("rst_pend_tac", BASE + 16'd3, 8'hF8);
        idle(1);
        peekIrq("rst_pend_irq2", 1'b0);
        idle(255);
        peek("rst_pend_div256", BASE, 8'h01);

        // Random bus traffic against the model
        for (int n = 0; n < 4000; n++) begin
            logic [15:0] a;
            logic [7:0]  d;
            int          r;
            r = $urandom_range(0, 9);
            if (r < 8)       a = BASE + 16'(r % 4);
            else if (r == 8) a = ($urandom_range(0, 1) == 0) ? BASE - 16'd1 : BASE + 16'd4;
            else             a = 16'($urandom);
            d = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            step($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, a, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
